mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store).
//  The pipeline datapath keeps its own IF/MEM request interfaces; this block grants exactly one of them per access.
//  It drives the shared memory and returns per-requester completion.
//  It produces stall_fetch/stall_mem for the hazard logic, which freezes the pipeline while an access is pending.
//  It also runs a watchdog against a non-responding memory.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width
//  STARVE_MAX  4   max consecutive DM grants while if_req is pending before IF is forced
//  TIMEOUT     64  cycles in a GRANT state without mem_ready before abort (>=2)
// PORTS
//  CLK         in   1       clock, all state updates on rising edge
//  RESET       in   1       synchronous, active-low reset
//  if_req      in   1       fetch request; held high with stable if_addr until if_valid
//  if_addr     in   ADDR_W  fetch address
//  if_rdata    out  DATA_W  fetch data, meaningful only when if_valid
//  if_valid    out  1       fetch completes this cycle
//  dm_req      in   1       data request; held high with stable inputs until dm_valid
//  dm_we       in   1       1=store, 0=load
//  dm_addr     in   ADDR_W  data address
//  dm_wdata    in   DATA_W  store data
//  dm_rdata    out  DATA_W  load data, meaningful only when dm_valid
//  dm_valid    out  1       data access completes this cycle
//  mem_req     out  1       registered; request to shared memory
//  mem_we      out  1       registered; write enable (0 for IF grants)
//  mem_addr    out  ADDR_W  registered; stable for the whole grant
//  mem_wdata   out  DATA_W  registered; stable for the whole grant
//  mem_rdata   in   DATA_W  read data, valid with mem_ready
//  mem_ready   in   1       access done this cycle
//  stall_fetch out  1       if_req & ~if_valid
//  stall_mem   out  1       dm_req & ~dm_valid
//  mem_err     out  1       sticky; set on watchdog abort
// BEHAVIOUR
//  FSM states: IDLE, GNT_IF, GNT_DM.
//  Reset (RESET=0 at edge):
//   - state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
//   - starve_cnt=0, wd_cnt=0, mem_err=0.
//   - Any in-flight access is dropped with no valid pulse.
//  IDLE arbitration, on an edge where a request is high:
//   - dm_req & if_req & starve_cnt==STARVE_MAX -> GNT_IF.
//   - dm_req otherwise -> GNT_DM (MEM is older, so it has priority).
//   - if_req only -> GNT_IF.
//   - On entry: latch that requester's addr, we and wdata into mem_*; mem_req=1.
//   - Request high in cycle N -> mem_req high in cycle N+1.
//  GNT_x, mem_ready=1:
//   - x_valid=1 combinationally; x_rdata = mem_rdata pass-through.
//   - Next state IDLE; mem_req=0; mem_we=0.
//   - One idle bubble follows every access, so back-to-back accesses take >=2 cycles.
//   - The requester drops or changes its request after that edge; no duplicate grant is possible.
//  GNT_x, mem_ready=0: hold state and all mem_* outputs; wd_cnt increments.
//  Watchdog:
//   - wd_cnt clears on every grant entry.
//   - If wd_cnt reaches TIMEOUT-1 with no mem_ready -> IDLE, mem_req=0, mem_err=1 (sticky until reset).
//   - No valid pulse on abort; the requester stays stalled and is re-arbitrated from IDLE.
//  starve_cnt:
//   - +1 (saturating at STARVE_MAX) on each GNT_DM entry while if_req=1.
//   - Cleared on GNT_IF entry, or on GNT_DM entry with if_req=0.
//  mem_ready outside GNT_* is ignored. if_valid and dm_valid are never high together.
//  rdata outputs are don't-care when valid=0; drive 0.
// TESTING
//  1) Reset, then only if_req=1, if_addr=0x40, mem_ready 2 cycles after mem_req=1, rdata=0x00500093
//     -> mem_addr=0x40, mem_we=0; if_valid one cycle with if_rdata=0x00500093; stall_fetch high until then.
//  2) Same cycle: if_req=1 @0x44, dm_req=1 we=1 @0x100 wdata=0xDEADBEEF
//     -> GNT_DM first (mem_we=1, mem_wdata=0xDEADBEEF); after 1 bubble, GNT_IF @0x44.
//  3) dm_req held continuously for 6 accesses plus if_req, mem_ready immediate
//     -> 4 DM grants, then IF grant, then DM resumes; starve_cnt returns to 0.
//  4) GNT_DM with mem_ready stuck 0 for TIMEOUT=64 cycles
//     -> IDLE, mem_req=0, mem_err=1, no dm_valid; mem_err stays 1 until RESET=0.
//  5) RESET=0 asserted mid GNT_IF (mem_ready=0)
//     -> next cycle: state IDLE, all mem_* outputs 0, no if_valid, counters 0.
//  6) mem_ready=1 while IDLE -> no valid pulse, no state change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Grants a single-ported unified memory to either instruction fetch or load/store, one access at a time.
// A request raised in cycle N drives mem_req in N+1, and completion follows mem_ready combinationally.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_fetch,
  output logic              stall_mem,
  output logic              mem_err
);

  localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;
  logic              dm_win, if_win;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    starve_d    = starve_q;
    wd_d        = wd_q;
    err_d       = err_q;
    dm_win      = 1'b0;
    if_win      = 1'b0;

    case (state_q)
      IDLE: begin
        // MEM is the older instruction and wins, unless fetch has waited out its quota
        dm_win = dm_req & ~(if_req & (starve_q == STARVE_LIM));
        if_win = if_req & ~dm_win;
        if (dm_win) begin
          state_d     = GNT_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          wd_d        = '0;
          if (if_req) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end
        end else if (if_win) begin
          state_d     = GNT_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          wd_d        = '0;
          starve_d    = '0;
        end
      end

      GNT_IF, GNT_DM: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else if (wd_q == WD_LAST) begin
          // abort silently; the requester stays stalled and is re-arbitrated
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      starve_q    <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      starve_q    <= starve_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_err   = err_q;

  assign if_valid = (state_q == GNT_IF) & mem_ready;
  assign dm_valid = (state_q == GNT_DM) & mem_ready;
  assign if_rdata = if_valid ? mem_rdata : '0;
  assign dm_rdata = dm_valid ? mem_rdata : '0;

  assign stall_fetch = if_req & ~if_valid;
  assign stall_mem   = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a cycle-stamped reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;
  localparam int TO = 64;

  logic          CLK;
  logic          RESET;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          stall_fetch;
  logic          stall_mem;
  logic          mem_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem_arr [logic [31:0]];

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_fetch(stall_fetch), .stall_mem(stall_mem), .mem_err(mem_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  task automatic drive_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic test_reset();
    RESET = 1'b0;
    clear_inputs();
    drive_edge();
    drive_edge();
    sample();
    n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); else n_pass++;
    n_checks++; if (mem_err !== 1'b0) $display("FAIL reset_mem_err: got %b want 0", mem_err); else n_pass++;
    n_checks++; if ({if_valid, dm_valid, stall_fetch, stall_mem} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {if_valid, dm_valid, stall_fetch, stall_mem}); else n_pass++;
    drive_edge();
    RESET = 1'b1;
    sample();
  endtask

  task automatic test_fetch();
    drive_edge();
    if_req = 1'b1; if_addr = 32'h40;
    sample();
    n_checks++; if (mem_req !== 1'b0) $display("FAIL fetch_req_c0: got %b want 0", mem_req); else n_pass++;
    n_checks++; if (stall_fetch !== 1'b1) $display("FAIL fetch_stall_c0: got %b want 1", stall_fetch); else n_pass++;
    drive_edge();
    sample();
    n_checks++; if ({mem_req, mem_we} !== 2'b10) $display("FAIL fetch_req_we_c1: got %b want 10", {mem_req, mem_we}); else n_pass++;
    n_checks++; if (mem_addr !== 32'h40) $display("FAIL fetch_addr_c1: got %h want 40", mem_addr); else n_pass++;
    drive_edge();
    sample();
    n_checks++; if ({mem_req, if_valid, stall_fetch} !== 3'b101) $display("FAIL fetch_wait_c2: got %b want 101", {mem_req, if_valid, stall_fetch}); else n_pass++;
    drive_edge();
    mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    sample();
    n_checks++; if ({if_valid, stall_fetch, dm_valid} !== 3'b100) $display("FAIL fetch_valid_c3: got %b want 100", {if_valid, stall_fetch, dm_valid}); else n_pass++;
    n_checks++; if (if_rdata !== 32'h0050_0093) $display("FAIL fetch_rdata_c3: got %h want 00500093", if_rdata); else n_pass++;
    drive_edge();
    if_req = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h1234_5678;
    sample();
    n_checks++; if ({mem_req, if_valid} !== 2'b00) $display("FAIL fetch_after_c4: got %b want 00", {mem_req, if_valid}); else n_pass++;
    n_checks++; if (if_rdata !== 32'h0) $display("FAIL fetch_rdata_zero_c4: got %h want 0", if_rdata); else n_pass++;
  endtask

  task automatic test_priority();
    drive_edge();
    if_req = 1'b1; if_addr = 32'h44;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    sample();
    n_checks++; if ({mem_req, stall_fetch, stall_mem} !== 3'b011) $display("FAIL prio_c0: got %b want 011", {mem_req, stall_fetch, stall_mem}); else n_pass++;
    drive_edge();
    mem_ready = 1'b1; mem_rdata = 32'h0;
    sample();
    n_checks++; if ({mem_req, mem_we} !== 2'b11) $display("FAIL prio_dm_req_we: got %b want 11", {mem_req, mem_we}); else n_pass++;
    n_checks++; if (mem_addr !== 32'h100) $display("FAIL prio_dm_addr: got %h want 100", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 32'hDEAD_BEEF) $display("FAIL prio_dm_wdata: got %h want deadbeef", mem_wdata); else n_pass++;
    n_checks++; if ({dm_valid, if_valid, stall_mem} !== 3'b100) $display("FAIL prio_dm_valid: got %b want 100", {dm_valid, if_valid, stall_mem}); else n_pass++;
    drive_edge();
    dm_req = 1'b0; dm_we = 1'b0;
    sample();
    n_checks++; if ({mem_req, if_valid, dm_valid} !== 3'b000) $display("FAIL prio_bubble: got %b want 000", {mem_req, if_valid, dm_valid}); else n_pass++;
    drive_edge();
    mem_rdata = 32'h1111_2222;
    sample();
    n_checks++; if ({mem_req, mem_we, if_valid} !== 3'b101) $display("FAIL prio_if_grant: got %b want 101", {mem_req, mem_we, if_valid}); else n_pass++;
    n_checks++; if (mem_addr !== 32'h44) $display("FAIL prio_if_addr: got %h want 44", mem_addr); else n_pass++;
    n_checks++; if (if_rdata !== 32'h1111_2222) $display("FAIL prio_if_rdata: got %h want 11112222", if_rdata); else n_pass++;
    drive_edge();
    if_req = 1'b0; mem_ready = 1'b0;
    sample();
    n_checks++; if (mem_req !== 1'b0) $display("FAIL prio_end: got %b want 0", mem_req); else n_pass++;
  endtask

  task automatic test_starvation();
    int exp_who [8];
    int ndone = 0, dm_done = 0, if_done = 0, last_cyc = -1, who;
    logic [31:0] exp_a;
    // four DM grants, forced fetch, two more DM grants, then the re-requested fetch
    exp_who = '{2, 2, 2, 2, 1, 2, 2, 1};
    drive_edge();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h48;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0000;
    for (int cyc = 0; cyc < 60 && ndone < 8; cyc++) begin
      sample();
      if (if_valid === 1'b1 || dm_valid === 1'b1) begin
        who = (if_valid === 1'b1) ? ((dm_valid === 1'b1) ? 3 : 1) : 2;
        exp_a = (exp_who[ndone] == 1) ? 32'h48 + 32'(4 * if_done) : 32'h200 + 32'(4 * dm_done);
        n_checks++; if (who != exp_who[ndone]) $display("FAIL starve_order #%0d: got %0d want %0d", ndone, who, exp_who[ndone]); else n_pass++;
        n_checks++; if (cyc - last_cyc != 2) $display("FAIL starve_gap #%0d: got %0d want 2", ndone, cyc - last_cyc); else n_pass++;
        n_checks++; if (mem_addr !== exp_a) $display("FAIL starve_addr #%0d: got %h want %h", ndone, mem_addr, exp_a); else n_pass++;
        last_cyc = cyc;
        ndone++;
        if (who == 1) if_done++; else dm_done++;
      end
      if (ndone < 8) begin
        drive_edge();
        if (dm_done >= 6) dm_req = 1'b0; else dm_addr = 32'h200 + 32'(4 * dm_done);
        if (if_done >= 2) if_req = 1'b0; else if_addr = 32'h48 + 32'(4 * if_done);
      end
    end
    n_checks++; if (ndone != 8) $display("FAIL starve_count: got %0d want 8", ndone); else n_pass++;
    drive_edge();
    clear_inputs();
    sample();
  endtask

  task automatic test_timeout();
    int hi = 0;
    drive_edge();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; mem_ready = 1'b0;
    sample();
    for (int i = 0; i < TO; i++) begin
      drive_edge();
      sample();
      if (mem_req === 1'b1 && dm_valid === 1'b0 && mem_err === 1'b0) hi++;
    end
    n_checks++; if (hi != TO) $display("FAIL wd_hold_cycles: got %0d want %0d", hi, TO); else n_pass++;
    drive_edge();
    sample();
    n_checks++; if ({mem_req, mem_err, dm_valid, stall_mem} !== 4'b0101) $display("FAIL wd_abort: got %b want 0101", {mem_req, mem_err, dm_valid, stall_mem}); else n_pass++;
    drive_edge();
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    sample();
    n_checks++; if ({mem_req, dm_valid, mem_err} !== 3'b111) $display("FAIL wd_regrant: got %b want 111", {mem_req, dm_valid, mem_err}); else n_pass++;
    n_checks++; if (dm_rdata !== 32'h0BAD_F00D) $display("FAIL wd_regrant_rdata: got %h want 0badf00d", dm_rdata); else n_pass++;
    drive_edge();
    dm_req = 1'b0; mem_ready = 1'b0;
    sample();
    n_checks++; if ({mem_req, mem_err} !== 2'b01) $display("FAIL wd_sticky: got %b want 01", {mem_req, mem_err}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive_edge();
    if_req = 1'b1; if_addr = 32'h80; mem_ready = 1'b0;
    sample();
    drive_edge();
    sample();
    n_checks++; if (mem_req !== 1'b1) $display("FAIL rstmid_granted: got %b want 1", mem_req); else n_pass++;
    drive_edge();
    RESET = 1'b0;
    sample();
    drive_edge();
    sample();
    n_checks++; if ({mem_req, mem_we, mem_err, if_valid} !== 4'b0) $display("FAIL rstmid_flags: got %b want 0000", {mem_req, mem_we, mem_err, if_valid}); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0) $display("FAIL rstmid_addr: got %h want 0", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 32'h0) $display("FAIL rstmid_wdata: got %h want 0", mem_wdata); else n_pass++;
    drive_edge();
    RESET = 1'b1; if_req = 1'b0;
    sample();
  endtask

  task automatic test_ready_idle();
    for (int i = 0; i < 3; i++) begin
      drive_edge();
      mem_ready = 1'b1; mem_rdata = 32'h55AA_55AA;
      sample();
      n_checks++; if ({mem_req, if_valid, dm_valid} !== 3'b000) $display("FAIL idle_ready_%0d: got %b want 000", i, {mem_req, if_valid, dm_valid}); else n_pass++;
      n_checks++; if ({if_rdata, dm_rdata} !== 64'h0) $display("FAIL idle_rdata_%0d: got %h want 0", i, {if_rdata, dm_rdata}); else n_pass++;
    end
    drive_edge();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
    sample();
    n_checks++; if ({mem_req, dm_valid} !== 2'b00) $display("FAIL idle_req_c0: got %b want 00", {mem_req, dm_valid}); else n_pass++;
    drive_edge();
    sample();
    n_checks++; if ({mem_req, dm_valid} !== 2'b11) $display("FAIL idle_req_c1: got %b want 11", {mem_req, dm_valid}); else n_pass++;
    drive_edge();
    clear_inputs();
    sample();
  endtask

  task automatic test_random();
    int owner = 0, streak = 0, g_start = 0, stuck = 0;
    logic err = 1'b0;
    logic m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, exp_ird, exp_drd;
    logic exp_if_v, exp_dm_v, seen_if_v = 1'b0, seen_dm_v = 1'b0;
    drive_edge();
    RESET = 1'b0;
    clear_inputs();
    drive_edge();
    RESET = 1'b1;
    mem_arr.delete();
    for (int k = 0; k < 3000; k++) begin
      if (k > 0) drive_edge();
      if (seen_if_v) if_req = 1'b0;
      if (seen_dm_v) dm_req = 1'b0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = 32'($urandom_range(0, 31)) << 2;
      end
      if (!dm_req && $urandom_range(0, 3) != 0) begin
        dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = 32'($urandom_range(0, 31)) << 2; dm_wdata = $urandom;
      end
      if (stuck > 0) begin
        stuck--; mem_ready = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        stuck = 70; mem_ready = 1'b0;
      end else begin
        mem_ready = ($urandom_range(0, 2) == 0);
      end
      mem_rdata = mem_ready ? mem_read(mem_addr) : $urandom;
      sample();

      exp_if_v = (owner == 1) && mem_ready;
      exp_dm_v = (owner == 2) && mem_ready;
      exp_ird  = exp_if_v ? mem_read(m_addr) : 32'h0;
      exp_drd  = exp_dm_v ? mem_read(m_addr) : 32'h0;
      n_checks++; if (mem_req !== (owner != 0)) $display("FAIL rnd_mem_req cyc %0d: got %b want %b", k, mem_req, owner != 0); else n_pass++;
      n_checks++; if ({if_valid, dm_valid} !== {exp_if_v, exp_dm_v}) $display("FAIL rnd_valid cyc %0d: got %b want %b", k, {if_valid, dm_valid}, {exp_if_v, exp_dm_v}); else n_pass++;
      n_checks++; if (if_rdata !== exp_ird) $display("FAIL rnd_if_rdata cyc %0d: got %h want %h", k, if_rdata, exp_ird); else n_pass++;
      n_checks++; if (dm_rdata !== exp_drd) $display("FAIL rnd_dm_rdata cyc %0d: got %h want %h", k, dm_rdata, exp_drd); else n_pass++;
      n_checks++; if ({stall_fetch, stall_mem} !== {if_req & ~exp_if_v, dm_req & ~exp_dm_v}) $display("FAIL rnd_stall cyc %0d: got %b want %b", k, {stall_fetch, stall_mem}, {if_req & ~exp_if_v, dm_req & ~exp_dm_v}); else n_pass++;
      n_checks++; if (mem_err !== err) $display("FAIL rnd_mem_err cyc %0d: got %b want %b", k, mem_err, err); else n_pass++;
      if (owner != 0) begin
        n_checks++; if ({mem_we, mem_addr} !== {m_we, m_addr}) $display("FAIL rnd_we_addr cyc %0d: got %b/%h want %b/%h", k, mem_we, mem_addr, m_we, m_addr); else n_pass++;
      end
      if (owner == 2) begin
        n_checks++; if (mem_wdata !== m_wdata) $display("FAIL rnd_wdata cyc %0d: got %h want %h", k, mem_wdata, m_wdata); else n_pass++;
      end

      if (exp_dm_v && m_we) mem_arr[m_addr] = m_wdata;
      seen_if_v = (if_valid === 1'b1);
      seen_dm_v = (dm_valid === 1'b1);

      if (owner == 0) begin
        if (dm_req && !(if_req && streak == SM)) begin
          owner = 2; m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata; g_start = k + 1;
          streak = if_req ? ((streak < SM) ? streak + 1 : SM) : 0;
        end else if (if_req) begin
          owner = 1; m_addr = if_addr; m_we = 1'b0; g_start = k + 1; streak = 0;
        end
      end else if (mem_ready) begin
        owner = 0;
      end else if (k - g_start + 1 == TO) begin
        owner = 0; err = 1'b1;
      end
    end
    drive_edge();
    clear_inputs();
    sample();
  endtask

  initial begin
    RESET = 1'b0;
    clear_inputs();
    test_reset();
    test_fetch();
    test_priority();
    test_starvation();
    test_timeout();
    test_reset_mid();
    test_ready_idle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
